// File: rtl/conf_reg_bank_rx.sv
// -----------------------------------------------------------------------------
// conf_reg_bank_rx
//
// Receive side of the configuration register bank. A host byte stream is
// parsed into frames: one address word followed by DATA_WIDTH/RX_WIDTH data
// words, least-significant word first. A frame addressed to a register writes
// that register as a whole when the last word has arrived. A frame whose
// header is READ_ALL_ADDR instead raises a one-cycle readback request for the
// downstream configuration shift register.
//
// Ports:
//   clk         - clock
//   rst         - synchronous, active-high reset
//   rx_data     - incoming word (address or data)
//   rx_valid    - rx_data is valid
//   rx_ack      - word consumed this cycle (combinational, independent of rx_valid)
//   registers   - flat register array, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   request     - one-cycle readback pulse toward the shift register
//   wr_strobe   - one-hot one-cycle pulse marking the register just written
//   err_addr    - one-cycle pulse: header neither a register nor READ_ALL_ADDR
//   err_timeout - one-cycle pulse: frame aborted after too long an idle gap
// -----------------------------------------------------------------------------
module conf_reg_bank_rx #(
    parameter int                    NUM_REGS       = 8,
    parameter int                    DATA_WIDTH     = 16,
    parameter int                    RX_WIDTH       = 8,
    parameter logic [RX_WIDTH-1:0]   READ_ALL_ADDR  = 8'hFF,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE    = '0,
    parameter int                    TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [RX_WIDTH-1:0]            rx_data,
    input  logic                           rx_valid,
    output logic                           rx_ack,
    output logic [DATA_WIDTH*NUM_REGS-1:0] registers,
    output logic                           request,
    output logic [NUM_REGS-1:0]            wr_strobe,
    output logic                           err_addr,
    output logic                           err_timeout
);

    localparam int BPW   = DATA_WIDTH / RX_WIDTH;
    localparam int CNT_W = $clog2(BPW) + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int AW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [RX_WIDTH-1:0] NUM_REGS_W = RX_WIDTH'(NUM_REGS);
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(BPW - 1);
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ADDR   = 2'd0,
        ST_DATA   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0] asm_q, asm_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic                  discard_q, discard_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic                  request_q, request_d;
    logic [NUM_REGS-1:0]   wr_strobe_q, wr_strobe_d;
    logic                  err_addr_q, err_addr_d;
    logic                  err_timeout_q, err_timeout_d;
    logic                  xfer;

    // The commit cycle is the only cycle in which no word can be taken; it
    // gives the register write its own edge.
    assign rx_ack = (state_q != ST_COMMIT);
    assign xfer   = rx_valid & rx_ack;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tmo_d         = tmo_q;
        asm_d         = asm_q;
        addr_d        = addr_q;
        discard_d     = discard_q;
        regs_d        = regs_q;
        request_d     = 1'b0;
        wr_strobe_d   = '0;
        err_addr_d    = 1'b0;
        err_timeout_d = 1'b0;

        case (state_q)
            ST_ADDR: begin
                if (xfer) begin
                    if (rx_data == READ_ALL_ADDR) begin
                        request_d = 1'b1;
                    end else if (rx_data < NUM_REGS_W) begin
                        addr_d    = rx_data[AW-1:0];
                        discard_d = 1'b0;
                        cnt_d     = '0;
                        tmo_d     = '0;
                        state_d   = ST_DATA;
                    end else begin
                        // Unknown header: still swallow the data words so the
                        // host stays in frame sync.
                        err_addr_d = 1'b1;
                        discard_d  = 1'b1;
                        cnt_d      = '0;
                        tmo_d      = '0;
                        state_d    = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (xfer) begin
                    for (int w = 0; w < BPW; w++) begin
                        if (cnt_q == CNT_W'(w)) begin
                            asm_d[w*RX_WIDTH +: RX_WIDTH] = rx_data;
                        end
                    end
                    cnt_d = cnt_q + 1'b1;
                    tmo_d = '0;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_COMMIT;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // Abort: the partial word set in asm_q is simply abandoned,
                    // no register has been touched yet.
                    err_timeout_d = 1'b1;
                    tmo_d         = '0;
                    cnt_d         = '0;
                    state_d       = ST_ADDR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            ST_COMMIT: begin
                if (!discard_q) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (addr_q == AW'(i)) begin
                            regs_d[i]      = asm_q;
                            wr_strobe_d[i] = 1'b1;
                        end
                    end
                end
                cnt_d   = '0;
                state_d = ST_ADDR;
            end

            default: begin
                state_d = ST_ADDR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_ADDR;
            cnt_q         <= '0;
            tmo_q         <= '0;
            asm_q         <= '0;
            addr_q        <= '0;
            discard_q     <= 1'b0;
            request_q     <= 1'b0;
            wr_strobe_q   <= '0;
            err_addr_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VALUE;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tmo_q         <= tmo_d;
            asm_q         <= asm_d;
            addr_q        <= addr_d;
            discard_q     <= discard_d;
            request_q     <= request_d;
            wr_strobe_q   <= wr_strobe_d;
            err_addr_q    <= err_addr_d;
            err_timeout_q <= err_timeout_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign registers[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

    assign request     = request_q;
    assign wr_strobe   = wr_strobe_q;
    assign err_addr    = err_addr_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_conf_reg_bank_rx.sv
// -----------------------------------------------------------------------------
// tb_conf_reg_bank_rx
//
// Bench for conf_reg_bank_rx with default parameters (8 x 16-bit registers,
// 8-bit words, read-all header 8'hFF, 1024-cycle idle timeout).
// -----------------------------------------------------------------------------
module tb_conf_reg_bank_rx;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ack;
    logic [127:0] registers;
    logic         request;
    logic [7:0]   wr_strobe;
    logic         err_addr;
    logic         err_timeout;

    conf_reg_bank_rx dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ack      (rx_ack),
        .registers   (registers),
        .request     (request),
        .wr_strobe   (wr_strobe),
        .err_addr    (err_addr),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // Free-running pulse counters; tests take differences of snapshots.
    int       n_req = 0, n_erra = 0, n_tmo = 0, n_wr = 0, n_multi = 0;
    logic [7:0] last_strobe = '0;

    always @(negedge clk) begin
        if (request)     n_req  = n_req + 1;
        if (err_addr)    n_erra = n_erra + 1;
        if (err_timeout) n_tmo  = n_tmo + 1;
        if (wr_strobe != 8'h00) begin
            n_wr        = n_wr + 1;
            last_strobe = wr_strobe;
            if ($countones(wr_strobe) != 1) n_multi = n_multi + 1;
        end
    end

    int nvec = 0;
    int nmis = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec = nvec + 1;
        if (act !== exp) begin
            nmis = nmis + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the register contents as the host would believe them.
    logic [15:0] mdl [8];

    function automatic logic [127:0] mdl_bus();
        logic [127:0] b;
        for (int i = 0; i < 8; i++) b[i*16 +: 16] = mdl[i];
        return b;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word after an optional idle gap; returns #1 after the edge
    // that transferred it. A word that is never accepted counts as a failure.
    task automatic send(input logic [7:0] w, input int gap);
        bit done;
        rx_valid = 1'b0;
        repeat (gap) tick();
        rx_data  = w;
        rx_valid = 1'b1;
        done     = 1'b0;
        for (int k = 0; k < 8 && !done; k++) begin
            @(negedge clk);
            if (rx_ack) done = 1'b1;
            tick();
        end
        rx_valid = 1'b0;
        if (!done) check("send_accept", 0, 1);
    endtask

    // High-level model of one frame: what the host intends it to do.
    task automatic mdl_frame(input logic [7:0] h, input logic [7:0] d0, input logic [7:0] d1,
                             output int e_req, output int e_erra, output int e_wr);
        e_req = 0; e_erra = 0; e_wr = 0;
        if (h == 8'hFF) e_req = 1;
        else if (h < 8) begin
            mdl[h] = {d1, d0};
            e_wr   = 1;
        end else e_erra = 1;
    endtask

    typedef struct {
        logic [7:0]  hdr;
        logic [7:0]  d0;
        logic [7:0]  d1;
        int          exp_req;
        int          exp_erra;
        int          exp_wr;
        logic [7:0]  exp_strobe;
        int          reg_idx;
        logic [15:0] exp_val;
    } vec_t;

    vec_t vt [10];

    initial begin
        int b_req, b_erra, b_tmo, b_wr;
        int e_req, e_erra, e_wr;
        logic [7:0] h, d0, d1;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        mdl_reset();

        vt[0] = '{8'h03, 8'h34, 8'h12, 0, 0, 1, 8'b0000_1000, 3, 16'h1234};
        vt[1] = '{8'hFF, 8'h00, 8'h00, 1, 0, 0, 8'b0000_1000, 3, 16'h1234};
        vt[2] = '{8'h09, 8'hAA, 8'hBB, 0, 1, 0, 8'b0000_1000, 3, 16'h1234};
        vt[3] = '{8'h00, 8'h01, 8'h00, 0, 0, 1, 8'b0000_0001, 0, 16'h0001};
        vt[4] = '{8'h07, 8'hEF, 8'hBE, 0, 0, 1, 8'b1000_0000, 7, 16'hBEEF};
        vt[5] = '{8'h08, 8'h11, 8'h22, 0, 1, 0, 8'b1000_0000, 0, 16'h0001};
        vt[6] = '{8'hFE, 8'h33, 8'h44, 0, 1, 0, 8'b1000_0000, 7, 16'hBEEF};
        vt[7] = '{8'h03, 8'h78, 8'h56, 0, 0, 1, 8'b0000_1000, 3, 16'h5678};
        vt[8] = '{8'h05, 8'hFF, 8'hFF, 0, 0, 1, 8'b0010_0000, 5, 16'hFFFF};
        vt[9] = '{8'hFF, 8'h00, 8'h00, 1, 0, 0, 8'b0010_0000, 5, 16'hFFFF};

        // Reset state after two reset cycles.
        tick();
        tick();
        check("reset_regs",   registers, 128'h0);
        check("reset_req",    request, 0);
        check("reset_strobe", wr_strobe, 0);
        check("reset_erra",   err_addr, 0);
        check("reset_etmo",   err_timeout, 0);
        check("reset_ack",    rx_ack, 1);
        rst = 1'b0;
        tick();

        // Write latency and commit-cycle rx_ack, hand sequenced.
        send(8'h03, 0);
        send(8'h34, 0);
        send(8'h12, 0);                       // last word taken at edge N
        check("lat_ack_commit", rx_ack, 0);
        check("lat_reg_early",  registers[3*16 +: 16], 16'h0000);
        check("lat_strobe_early", wr_strobe, 0);
        tick();                               // edge N+1
        check("lat_reg3",    registers[3*16 +: 16], 16'h1234);
        check("lat_strobe",  wr_strobe, 8'b0000_1000);
        check("lat_others",  {registers[127:64], registers[47:0]}, 112'h0);
        check("lat_ack_back", rx_ack, 1);
        tick();
        check("lat_strobe_gone", wr_strobe, 0);

        // Back-to-back readback headers.
        rx_data  = 8'hFF;
        rx_valid = 1'b1;
        tick();
        check("b2b_req1", request, 1);
        tick();
        rx_valid = 1'b0;
        check("b2b_req2", request, 1);
        tick();
        check("b2b_req_end", request, 0);
        check("b2b_regs", registers, {112'h0, 16'h1234} << 48);
        mdl_reset();
        mdl[3] = 16'h1234;

        // Table-driven frames.
        for (int i = 0; i < 10; i++) begin
            b_req = n_req; b_erra = n_erra; b_wr = n_wr;
            send(vt[i].hdr, 0);
            if (vt[i].hdr != 8'hFF) begin
                send(vt[i].d0, 0);
                send(vt[i].d1, 0);
            end
            tick();
            tick();
            mdl_frame(vt[i].hdr, vt[i].d0, vt[i].d1, e_req, e_erra, e_wr);
            check($sformatf("vec%0d_req", i),  n_req - b_req,   vt[i].exp_req);
            check($sformatf("vec%0d_erra", i), n_erra - b_erra, vt[i].exp_erra);
            check($sformatf("vec%0d_wr", i),   n_wr - b_wr,     vt[i].exp_wr);
            check($sformatf("vec%0d_strobe", i), last_strobe,   vt[i].exp_strobe);
            check($sformatf("vec%0d_reg", i),
                  registers[vt[i].reg_idx*16 +: 16], vt[i].exp_val);
        end
        check("table_bus", registers, mdl_bus());

        // Timeout: frame stalls after one data word.
        b_tmo = n_tmo; b_wr = n_wr;
        send(8'h02, 0);
        send(8'h55, 0);
        repeat (1000) tick();
        check("tmo_not_early", n_tmo - b_tmo, 0);
        repeat (30) tick();
        check("tmo_pulse", n_tmo - b_tmo, 1);
        check("tmo_no_write", n_wr - b_wr, 0);
        check("tmo_reg2", registers[2*16 +: 16], mdl[2]);
        b_wr = n_wr;
        send(8'h02, 0);
        send(8'h66, 0);
        send(8'h77, 0);
        tick();
        tick();
        mdl[2] = 16'h7766;
        check("tmo_next_reg2", registers[2*16 +: 16], 16'h7766);
        check("tmo_next_wr", n_wr - b_wr, 1);

        // Randomized frames with short idle gaps against the model.
        for (int f = 0; f < 150; f++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 5)      h = 8'($urandom_range(0, 7));
            else if (r == 6) h = 8'hFF;
            else             h = 8'($urandom_range(8, 254));
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            b_req = n_req; b_erra = n_erra; b_wr = n_wr; b_tmo = n_tmo;
            send(h, $urandom_range(0, 2));
            if (h != 8'hFF) begin
                send(d0, $urandom_range(0, 3));
                send(d1, $urandom_range(0, 3));
            end
            tick();
            tick();
            mdl_frame(h, d0, d1, e_req, e_erra, e_wr);
            check("rnd_events", {n_req - b_req, n_erra - b_erra, n_wr - b_wr, n_tmo - b_tmo},
                  {e_req, e_erra, e_wr, 32'd0});
            if (e_wr == 1) check("rnd_strobe", last_strobe, 8'h01 << h);
            check("rnd_bus", registers, mdl_bus());
        end
        check("onehot_strobe", n_multi, 0);

        // Reset in the middle of a frame.
        send(8'h01, 0);
        send(8'hAB, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mdl_reset();
        check("midrst_regs", registers, 128'h0);
        b_wr = n_wr; b_erra = n_erra;
        send(8'hCD, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        tick();
        tick();
        check("midrst_reg1", registers[1*16 +: 16], 16'h0000);
        check("midrst_no_wr", n_wr - b_wr, 0);
        check("midrst_erra", n_erra - b_erra, 1);
        check("midrst_bus", registers, mdl_bus());

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
